// File: rtl/pixel_plot_arbiter_if.sv
// Pixel-stream interface between the character drawing FSM (master) and
// the plot arbiter (slave).
//   Start                 : one-cycle pulse, begin a frame update
//   Erase*                : old-position pixel stream (valid/ready/last)
//   Draw*                 : new-position pixel stream (valid/ready/last, colour)
//   Vga*                  : VGA adapter plot port driven by the arbiter
//   DoneDrawing           : one-cycle strobe when the update completes
//   Busy/TimeoutFlag/ClipCount : status returned to the producer
interface pixel_plot_arbiter_if;
  logic       Start;
  logic       EraseValid;
  logic       EraseReady;
  logic [7:0] EraseX;
  logic [6:0] EraseY;
  logic       EraseLast;
  logic       DrawValid;
  logic       DrawReady;
  logic [7:0] DrawX;
  logic [6:0] DrawY;
  logic [2:0] DrawColor;
  logic       DrawLast;
  logic [7:0] VgaX;
  logic [6:0] VgaY;
  logic [2:0] VgaColor;
  logic       VgaPlot;
  logic       DoneDrawing;
  logic       Busy;
  logic       TimeoutFlag;
  logic [7:0] ClipCount;

  modport master (
    output Start, EraseValid, EraseX, EraseY, EraseLast,
           DrawValid, DrawX, DrawY, DrawColor, DrawLast,
    input  EraseReady, DrawReady, VgaX, VgaY, VgaColor, VgaPlot,
           DoneDrawing, Busy, TimeoutFlag, ClipCount
  );

  modport slave (
    input  Start, EraseValid, EraseX, EraseY, EraseLast,
           DrawValid, DrawX, DrawY, DrawColor, DrawLast,
    output EraseReady, DrawReady, VgaX, VgaY, VgaColor, VgaPlot,
           DoneDrawing, Busy, TimeoutFlag, ClipCount
  );
endinterface

// File: rtl/pixel_plot_arbiter.sv
// Receiving end of the character pixel stream. One frame update erases the
// old sprite (every pixel written in BG_COLOR) and then draws the new one,
// one pixel per valid/ready handshake, and finishes with a one-cycle
// DoneDrawing strobe. Off-screen pixels are accepted but not plotted.
//   CLOCK_50 : system clock
//   Reset    : asynchronous, active-low reset
//   bus      : pixel_plot_arbiter_if.slave (streams, plot port, status)
module pixel_plot_arbiter #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter logic [2:0]  BG_COLOR = 3'b000,
  parameter int unsigned PLOT_GAP = 0,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  pixel_plot_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A zero gap still needs a 1-bit counter so the vector is legal.
  localparam int GAP_W = (PLOT_GAP < 1) ? 1 : $clog2(PLOT_GAP + 1);

  state_t           r_state;
  logic [GAP_W-1:0] r_gap;
  logic [9:0]       r_tmo;
  logic [7:0]       r_vga_x;
  logic [6:0]       r_vga_y;
  logic [2:0]       r_vga_color;
  logic             r_plot;
  logic             r_done;
  logic             r_tmo_flag;
  logic [7:0]       r_clip;

  logic       w_gap_free;
  logic       w_erase_ready;
  logic       w_draw_ready;
  logic       w_hs;
  logic [7:0] w_px_x;
  logic [6:0] w_px_y;
  logic [2:0] w_px_color;
  logic       w_px_last;
  logic       w_clipped;

  assign w_gap_free    = (r_gap == '0);
  assign w_erase_ready = (r_state == S_ERASE) && w_gap_free;
  assign w_draw_ready  = (r_state == S_DRAW)  && w_gap_free;
  assign w_hs          = (bus.EraseValid && w_erase_ready) ||
                         (bus.DrawValid  && w_draw_ready);

  // Only one channel can be ready at a time, so the state selects the source.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_px_x     = bus.EraseX;
    w_px_y     = bus.EraseY;
    w_px_color = BG_COLOR;
    w_px_last  = bus.EraseLast;
    if (r_state == S_DRAW) begin
      w_px_x     = bus.DrawX;
      w_px_y     = bus.DrawY;
      w_px_color = bus.DrawColor;
      w_px_last  = bus.DrawLast;
    end
  end

  assign w_clipped = (32'(w_px_x) >= SCREEN_W) || (32'(w_px_y) >= SCREEN_H);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_gap       <= '0;
      r_tmo       <= '0;
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_color <= '0;
      r_plot      <= 1'b0;
      r_done      <= 1'b0;
      r_tmo_flag  <= 1'b0;
      r_clip      <= '0;
    end else begin
      r_plot <= 1'b0;
      r_done <= 1'b0;

      // Ready stays low until the gap has drained after each accepted pixel.
      if (w_hs) begin
        r_gap <= GAP_W'(PLOT_GAP);
      end else if (!w_gap_free) begin
        r_gap <= r_gap - GAP_W'(1);
      end

      // Accepted pixels reach the plot port one cycle later; clipped ones
      // are only counted and leave the plot registers untouched.
      if (w_hs) begin
        if (w_clipped) begin
          if (r_clip != 8'hFF) r_clip <= r_clip + 8'd1;
        end else begin
          r_vga_x     <= w_px_x;
          r_vga_y     <= w_px_y;
          r_vga_color <= w_px_color;
          r_plot      <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (bus.Start) begin
            r_state    <= S_ERASE;
            r_tmo_flag <= 1'b0;
            r_clip     <= '0;
          end
        end
        S_ERASE, S_DRAW: begin
          if (w_hs) begin
            r_tmo <= '0;
            if (w_px_last) begin
              if (r_state == S_ERASE) begin
                r_state <= S_DRAW;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end else if (r_tmo == 10'(TIMEOUT - 1)) begin
            // Producer stalled: abandon the update without DoneDrawing.
            r_tmo      <= '0;
            r_tmo_flag <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 10'd1;
          end
        end
        S_DONE: begin
          r_tmo   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.EraseReady  = w_erase_ready;
  assign bus.DrawReady   = w_draw_ready;
  assign bus.VgaX        = r_vga_x;
  assign bus.VgaY        = r_vga_y;
  assign bus.VgaColor    = r_vga_color;
  assign bus.VgaPlot     = r_plot;
  assign bus.DoneDrawing = r_done;
  assign bus.Busy        = (r_state != S_IDLE);
  assign bus.TimeoutFlag = r_tmo_flag;
  assign bus.ClipCount   = r_clip;

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// Self-checking bench for pixel_plot_arbiter. Instance A uses PLOT_GAP=0 and
// TIMEOUT=15; instance B uses PLOT_GAP=2. Outputs are sampled 1 time unit
// after the rising edge; inputs are driven at the same point.
module tb_pixel_plot_arbiter;

  localparam int A_GAP = 0;
  localparam int TMO   = 15;
  localparam int PH_IDLE = 0, PH_ERASE = 1, PH_DRAW = 2, PH_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pixel_plot_arbiter_if a_if ();
  pixel_plot_arbiter_if b_if ();

  pixel_plot_arbiter #(.PLOT_GAP(A_GAP), .TIMEOUT(TMO)) u_dut_a (
    .CLOCK_50(clk), .Reset(rst_n), .bus(a_if)
  );
  pixel_plot_arbiter #(.PLOT_GAP(2), .TIMEOUT(TMO)) u_dut_b (
    .CLOCK_50(clk), .Reset(rst_n), .bus(b_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic st, ev, input logic [7:0] ex, input logic [6:0] ey,
                         input logic el, dv, input logic [7:0] dx, input logic [6:0] dy,
                         input logic [2:0] dc, input logic dl);
    a_if.Start = st;  a_if.EraseValid = ev; a_if.EraseX = ex; a_if.EraseY = ey;
    a_if.EraseLast = el; a_if.DrawValid = dv; a_if.DrawX = dx; a_if.DrawY = dy;
    a_if.DrawColor = dc; a_if.DrawLast = dl;
  endtask

  task automatic idle_a();
    drive_a(0, 0, 8'd0, 7'd0, 0, 0, 8'd0, 7'd0, 3'd0, 0);
  endtask

  task automatic idle_b();
    b_if.Start = 0; b_if.EraseValid = 0; b_if.EraseX = 0; b_if.EraseY = 0;
    b_if.EraseLast = 0; b_if.DrawValid = 0; b_if.DrawX = 0; b_if.DrawY = 0;
    b_if.DrawColor = 0; b_if.DrawLast = 0;
  endtask

  // {plot, x, y, colour, done, busy, eready, dready, flag, clipcount} = 32 bits
  function automatic logic [31:0] pack_a();
    return {a_if.VgaPlot, a_if.VgaX, a_if.VgaY, a_if.VgaColor, a_if.DoneDrawing,
            a_if.Busy, a_if.EraseReady, a_if.DrawReady, a_if.TimeoutFlag, a_if.ClipCount};
  endfunction

  task automatic pulse_reset();
    idle_a();
    idle_b();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- table-driven basic frame ----------------
  typedef struct {
    logic       start, ev;
    logic [7:0] ex;
    logic [6:0] ey;
    logic       el, dv;
    logic [7:0] dx;
    logic [6:0] dy;
    logic [2:0] dc;
    logic       dl;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       done, busy, er, dr;
  } vec_t;

  vec_t vecs[9];

  task automatic run_table(input string tag);
    for (int i = 0; i < 9; i++) begin
      drive_a(vecs[i].start, vecs[i].ev, vecs[i].ex, vecs[i].ey, vecs[i].el,
              vecs[i].dv, vecs[i].dx, vecs[i].dy, vecs[i].dc, vecs[i].dl);
      tick();
      check($sformatf("%s_row%0d", tag, i), pack_a(),
            {vecs[i].plot, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].done,
             vecs[i].busy, vecs[i].er, vecs[i].dr, 1'b0, 8'd0});
    end
    idle_a();
  endtask

  // ---------------- behavioural reference model ----------------
  // Gap is modelled by timestamps: a channel is ready when more than PLOT_GAP
  // cycles have passed since the last accepted pixel.
  int         m_phase, m_cyc, m_last_hs, m_quiet, m_clip;
  bit         m_flag, m_plot, m_done;
  bit [7:0]   m_x;
  bit [6:0]   m_y;
  bit [2:0]   m_c;

  task automatic m_reset();
    m_phase = PH_IDLE; m_cyc = 0; m_last_hs = -1000; m_quiet = 0; m_clip = 0;
    m_flag = 0; m_plot = 0; m_done = 0; m_x = 0; m_y = 0; m_c = 0;
  endtask

  function automatic bit m_ready(input int ph);
    return (m_phase == ph) && (m_cyc - m_last_hs > A_GAP);
  endfunction

  function automatic logic [31:0] m_pack();
    return {m_plot, m_x, m_y, m_c, m_done, (m_phase != PH_IDLE),
            m_ready(PH_ERASE), m_ready(PH_DRAW), m_flag, 8'(m_clip)};
  endfunction

  task automatic model_edge(input bit st, ev, input int ex, ey, input bit el, dv,
                            input int dx, dy, input int dc, input bit dl);
    bit hs, last;
    int px, py, pc;
    hs = 0; last = 0; px = 0; py = 0; pc = 0;
    if (m_ready(PH_ERASE) && ev) begin hs = 1; px = ex; py = ey; pc = 0;  last = el; end
    if (m_ready(PH_DRAW)  && dv) begin hs = 1; px = dx; py = dy; pc = dc; last = dl; end
    m_plot = 0;
    m_done = 0;
    if (hs) begin
      m_last_hs = m_cyc;
      if (px >= 160 || py >= 120) m_clip = (m_clip < 255) ? m_clip + 1 : 255;
      else begin m_plot = 1; m_x = 8'(px); m_y = 7'(py); m_c = 3'(pc); end
    end
    case (m_phase)
      PH_IDLE: if (st) begin m_phase = PH_ERASE; m_flag = 0; m_clip = 0; m_quiet = 0; end
      PH_ERASE, PH_DRAW: begin
        if (hs) begin
          m_quiet = 0;
          if (last) begin
            if (m_phase == PH_ERASE) m_phase = PH_DRAW;
            else begin m_phase = PH_DONE; m_done = 1; end
          end
        end else begin
          m_quiet++;
          if (m_quiet >= TMO) begin m_flag = 1; m_phase = PH_IDLE; m_quiet = 0; end
        end
      end
      default: m_phase = PH_IDLE;
    endcase
    m_cyc++;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    //            st ev ex  ey el dv dx  dy dc dl | plot x  y  c  done busy er dr
    vecs[0] = '{1, 0, 0,  0, 0, 0, 0,  0, 0, 0,    0, 0,  0, 0, 0, 1, 1, 0};
    vecs[1] = '{0, 1, 10, 20, 0, 0, 0,  0, 0, 0,   1, 10, 20, 0, 0, 1, 1, 0};
    vecs[2] = '{0, 1, 11, 20, 0, 0, 0,  0, 0, 0,   1, 11, 20, 0, 0, 1, 1, 0};
    vecs[3] = '{0, 1, 12, 20, 1, 0, 0,  0, 0, 0,   1, 12, 20, 0, 0, 1, 0, 1};
    vecs[4] = '{0, 1, 99, 99, 0, 1, 10, 21, 5, 0,  1, 10, 21, 5, 0, 1, 0, 1};
    vecs[5] = '{1, 0, 0,  0, 0, 1, 11, 21, 5, 0,   1, 11, 21, 5, 0, 1, 0, 1};
    vecs[6] = '{0, 0, 0,  0, 0, 1, 12, 21, 5, 1,   1, 12, 21, 5, 1, 1, 0, 0};
    vecs[7] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,    0, 12, 21, 5, 0, 0, 0, 0};
    vecs[8] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0,    0, 12, 21, 5, 0, 0, 0, 0};

    idle_a();
    idle_b();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_state_a", pack_a(), 32'd0);
    check("reset_state_b", 32'({b_if.VgaPlot, b_if.Busy, b_if.EraseReady, b_if.DrawReady}), 32'd0);

    // Basic frame, including a Start pulse while in DRAW that must be ignored.
    run_table("basic");

    // Clipping: (160,5) is swallowed, (159,119) is plotted and ends the frame.
    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);     tick();
    drive_a(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);     tick();
    check("clip_erase_plot", 32'(a_if.VgaPlot), 32'd1);
    drive_a(0, 0, 0, 0, 0, 1, 160, 5, 3, 0);   tick();
    check("clip_offscreen_plot", 32'(a_if.VgaPlot), 32'd0);
    check("clip_offscreen_hold", 32'({a_if.VgaX, a_if.VgaY}), 32'({8'd1, 7'd1}));
    check("clip_count_1", 32'(a_if.ClipCount), 32'd1);
    drive_a(0, 0, 0, 0, 0, 1, 159, 119, 3, 1); tick();
    check("clip_last_plot", 32'({a_if.VgaPlot, a_if.VgaX, a_if.VgaY, a_if.VgaColor, a_if.DoneDrawing}),
          32'({1'b1, 8'd159, 7'd119, 3'd3, 1'b1}));
    idle_a(); tick();
    check("clip_after", 32'({a_if.Busy, a_if.ClipCount}), 32'({1'b0, 8'd1}));

    // Timeout: Start then hold EraseValid low for TMO cycles.
    begin
      int done_seen;
      done_seen = 0;
      drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      idle_a();
      check("tmo_start", 32'({a_if.Busy, a_if.TimeoutFlag, a_if.ClipCount}), 32'({1'b1, 1'b0, 8'd0}));
      for (int k = 1; k < TMO; k++) begin
        tick();
        done_seen += int'(a_if.DoneDrawing);
      end
      check("tmo_busy_before", 32'(a_if.Busy), 32'd1);
      tick();
      done_seen += int'(a_if.DoneDrawing);
      check("tmo_abort", 32'({a_if.Busy, a_if.TimeoutFlag}), 32'({1'b0, 1'b1}));
      tick();
      check("tmo_flag_sticky", 32'(a_if.TimeoutFlag), 32'd1);
      check("tmo_no_done", 32'(done_seen), 32'd0);
      drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      idle_a();
      check("tmo_restart_clears", 32'({a_if.Busy, a_if.TimeoutFlag}), 32'({1'b1, 1'b0}));
      repeat (TMO + 1) tick();
    end

    // PLOT_GAP = 2 on instance B with EraseValid held high.
    b_if.Start = 1; tick();
    b_if.Start = 0; b_if.EraseValid = 1; b_if.EraseX = 20; b_if.EraseY = 30;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("gap_ready_%0d", k), 32'(b_if.EraseReady), 32'((k % 3) == 0));
      check($sformatf("gap_plot_%0d", k), 32'(b_if.VgaPlot), 32'((k % 3) == 1));
      tick();
    end
    idle_b();

    // Asynchronous reset in the middle of ERASE.
    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive_a(0, 1, 5, 5, 0, 0, 0, 0, 0, 0); tick();
    check("rst_pre_plot", 32'(a_if.VgaPlot), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", 32'({a_if.VgaPlot, a_if.Busy, a_if.EraseReady, a_if.DrawReady}), 32'd0);
    idle_a();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_table("after_reset");

    // Randomized traffic against the reference model.
    pulse_reset();
    m_reset();
    begin
      int mode;
      bit st, ev, el, dv, dl;
      int ex, ey, dx, dy, dc;
      mode = 2;
      for (int i = 0; i < 2000; i++) begin
        if (i % 100 == 0) mode = $urandom_range(0, 2);
        st = ($urandom_range(0, 15) == 0);
        ev = (mode == 0) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) != 0);
        dv = (mode == 0) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) != 0);
        ex = $urandom_range(0, 175); ey = $urandom_range(0, 127);
        dx = $urandom_range(0, 175); dy = $urandom_range(0, 127);
        dc = $urandom_range(0, 7);
        el = ($urandom_range(0, 4) == 0);
        dl = ($urandom_range(0, 4) == 0);
        drive_a(st, ev, 8'(ex), 7'(ey), el, dv, 8'(dx), 7'(dy), 3'(dc), dl);
        model_edge(st, ev, ex, ey, el, dv, dx, dy, dc, dl);
        tick();
        check($sformatf("rand_%0d", i), pack_a(), m_pack());
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_plot_arbiter.md
Name: pixel_plot_arbiter

Overview:
- Receiving end of the character pixel-stream interface.
- Accepts the erase stream (old position) and the draw stream (new position), one pixel per valid/ready handshake, strictly erase-then-draw per frame update.
- Drives the VGA adapter plot port and returns the single-cycle DoneDrawing strobe that the character FSM waits on before its next move.

Parameters:
SCREEN_W, 160, visible width; pixels with X >= SCREEN_W are clipped
SCREEN_H, 120, visible height; pixels with Y >= SCREEN_H are clipped
BG_COLOR, 3'b000, colour written for every erase pixel
PLOT_GAP, 0, idle cycles forced between accepted pixels (0 = one pixel per cycle)
TIMEOUT, 1023, cycles without a handshake in ERASE/DRAW before abort (counter 10 bits)

Ports:
CLOCK_50  in  1  system clock
Reset  in  1  asynchronous, active-low reset
Start  in  1  single-cycle pulse: begin one frame update
EraseValid  in  1  erase pixel available
EraseReady  out  1  arbiter accepts erase pixel this cycle
EraseX  in  8  erase pixel X
EraseY  in  7  erase pixel Y
EraseLast  in  1  marks final erase pixel
DrawValid  in  1  draw pixel available
DrawReady  out  1  arbiter accepts draw pixel this cycle
DrawX  in  8  draw pixel X
DrawY  in  7  draw pixel Y
DrawColor  in  3  draw pixel colour
DrawLast  in  1  marks final draw pixel
VgaX  out  8  plot X
VgaY  out  7  plot Y
VgaColor  out  3  plot colour
VgaPlot  out  1  plot write enable, one cycle per pixel
DoneDrawing  out  1  one-cycle pulse when the frame update completes
Busy  out  1  high in any state other than IDLE
TimeoutFlag  out  1  sticky abort indicator
ClipCount  out  8  clipped pixels in the current/last update, saturating at 255

Behaviour:
- Reset low, asynchronous:
  - state IDLE; all outputs 0; gap, timeout and clip counters 0.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - EraseReady = DrawReady = 0.
  - Start=1 moves to ERASE next cycle, clears TimeoutFlag and ClipCount.
- ERASE:
  - EraseReady = 1 when the gap counter is 0; DrawReady = 0.
  - Handshake = EraseValid & EraseReady.
- DRAW:
  - Same rules as ERASE, applied to the Draw channel; EraseReady = 0.
- Handshake actions:
  - Latch X/Y and colour (BG_COLOR for erase, DrawColor for draw) into the output register.
  - Next cycle: VgaX/VgaY/VgaColor hold those values and VgaPlot = 1 (latency 1). Otherwise VgaPlot = 0.
  - VgaX/Y/Color hold their last values while VgaPlot = 0.
- PLOT_GAP:
  - Each handshake loads the gap counter with PLOT_GAP; it decrements each cycle, and Ready is low while it is nonzero.
  - PLOT_GAP = 0 allows back-to-back handshakes.
- Clipping:
  - A pixel with X >= SCREEN_W or Y >= SCREEN_H is still accepted (handshake completes, gap applies).
  - It raises no VgaPlot; ClipCount increments, saturating at 255.
- Last:
  - Erase handshake with EraseLast → DRAW next cycle.
  - Draw handshake with DrawLast → DONE next cycle.
  - Last on a clipped pixel behaves identically.
- DONE:
  - Lasts one cycle: DoneDrawing = 1, then IDLE.
  - The plot of the final draw pixel appears in this same DONE cycle.
- Start outside IDLE is ignored; no queuing.
- Valid while not Ready: no effect. The producer must hold its data; the arbiter samples only on handshake.
- Timeout:
  - The counter increments each cycle in ERASE/DRAW with no handshake and clears on any handshake or state change.
  - Reaching TIMEOUT sets TimeoutFlag, state → IDLE, no DoneDrawing.
  - Flag holds until the next accepted Start or reset.
- Busy = (state != IDLE), including the DONE cycle.
- Reset mid-operation: immediate return to IDLE; any pending plot is dropped (VgaPlot = 0).

Test Plan:
- Basic: Start, 3 erase pixels (10,20),(11,20),(12,20) with Last on the 3rd, then 3 draw pixels (10,21)…(12,21) colour 3'b101.
  - Required: 6 VgaPlot cycles, erase pixels first with VgaColor = 000, each 1 cycle after its handshake.
  - DoneDrawing pulses exactly once, on the cycle of the last plot; Busy falls the cycle after.
- PLOT_GAP = 2, with Valid held high:
  - Required: EraseReady pattern 1,0,0,1,0,0…; VgaPlot spaced 3 cycles apart.
- Clipping: draw pixel (160,5) then (159,119) with Last.
  - Required: only (159,119) is plotted; ClipCount = 1; DoneDrawing still pulses.
- Timeout, TIMEOUT = 15: Start, then hold EraseValid low.
  - Required: TimeoutFlag = 1 and state IDLE after 15 cycles, DoneDrawing never asserted.
  - A subsequent Start clears TimeoutFlag.
- Start during DRAW:
  - Required: ignored; the frame completes normally with exactly one DoneDrawing.
- Reset mid-operation: assert Reset low during ERASE after 1 handshake.
  - Required: VgaPlot, Busy, and both Ready outputs = 0 immediately (asynchronous).
  - After release, a new Start runs a full update.
